// File: rtl/cacheline_arbiter.sv
// ---------------------------------------------------------------------------
// cacheline_arbiter
//
// Shares the single cacheline adaptor port between the instruction cache and
// the data cache. One 256-bit line read or write is in flight at a time. The
// winner's address, write data and operation are latched on the grant edge.
// They are then driven downstream, unchanged, until the adaptor answers with
// mem_resp. The response is routed combinationally back to the winner.
// Ties are broken round-robin, so neither cache can starve the other.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   i_address/i_read/i_write/i_wdata   icache request side (inputs)
//   i_rdata/i_resp                     icache response side (outputs)
//   d_address/d_read/d_write/d_wdata   dcache request side (inputs)
//   d_rdata/d_resp                     dcache response side (outputs)
//   mem_address/mem_read/mem_write/mem_wdata   request to adaptor (outputs)
//   mem_rdata/mem_resp                         response from adaptor (inputs)
// ---------------------------------------------------------------------------
module cacheline_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RECOVER} state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;
    typedef enum logic {OP_READ, OP_WRITE} op_t;

    state_t            r_state;
    port_t             r_lastGrant;
    op_t               r_latchOp;
    logic [ADDR_W-1:0] r_latchAddr;
    logic [LINE_W-1:0] r_latchData;

    logic w_iPend;
    logic w_dPend;
    logic w_grantI;
    logic w_grantD;
    logic w_iBusy;
    logic w_dBusy;
    logic w_busy;

    // A port is pending on either request line. On a tie, the port that was
    // not served last wins.
    assign w_iPend  = i_read | i_write;
    assign w_dPend  = d_read | d_write;
    assign w_grantI = w_iPend & (~w_dPend | (r_lastGrant == PORT_D));
    assign w_grantD = w_dPend & ~w_grantI;

    // Arbitration FSM. The requester's fields are captured only on the grant
    // edge, so later input changes cannot reach the adaptor. RECOVER gives
    // the adaptor and the requester one quiet cycle before the next grant.
    // A read+write request is treated as a read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_lastGrant <= PORT_D;
            r_latchOp   <= OP_READ;
            r_latchAddr <= '0;
            r_latchData <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grantI) begin
                        r_state     <= I_BUSY;
                        r_lastGrant <= PORT_I;
                        r_latchAddr <= i_address;
                        r_latchData <= i_wdata;
                        r_latchOp   <= i_read ? OP_READ : OP_WRITE;
                    end else if (w_grantD) begin
                        r_state     <= D_BUSY;
                        r_lastGrant <= PORT_D;
                        r_latchAddr <= d_address;
                        r_latchData <= d_wdata;
                        r_latchOp   <= d_read ? OP_READ : OP_WRITE;
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (mem_resp) begin
                        r_state <= RECOVER;
                    end
                end
                RECOVER: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_iBusy = (r_state == I_BUSY);
    assign w_dBusy = (r_state == D_BUSY);
    assign w_busy  = w_iBusy | w_dBusy;

    // The downstream port is driven purely from the latches and the state.
    // As a result, it goes quiet immediately when reset is asserted, and it
    // is all-zero in IDLE and RECOVER.
    assign mem_address = w_busy ? r_latchAddr : '0;
    assign mem_wdata   = w_busy ? r_latchData : '0;
    assign mem_read    = w_busy & (r_latchOp == OP_READ);
    assign mem_write   = w_busy & (r_latchOp == OP_WRITE);

    // Responses pass straight through to the winner in the same cycle. A
    // stray mem_resp outside BUSY never reaches either cache.
    assign i_resp  = w_iBusy & mem_resp;
    assign d_resp  = w_dBusy & mem_resp;
    assign i_rdata = i_resp ? mem_rdata : '0;
    assign d_rdata = d_resp ? mem_rdata : '0;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cacheline_arbiter
//
// Directed bench for cacheline_arbiter. The bench acts as both caches and as
// the adaptor. Inputs change and outputs are sampled just after the falling
// clock edge. Every expected value is written out by hand.
// ---------------------------------------------------------------------------
module tb_cacheline_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    localparam logic [LINE_W-1:0] LINE_A = {32{8'hAA}};
    localparam logic [LINE_W-1:0] LINE_B = {32{8'h5C}};
    localparam logic [LINE_W-1:0] LINE_W0 = {8{32'h12345678}};

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] i_address;
    logic              i_read;
    logic              i_write;
    logic [LINE_W-1:0] i_wdata;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic [ADDR_W-1:0] d_address;
    logic              d_read;
    logic              d_write;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    int compareCount  = 0;
    int mismatchCount = 0;
    int cycles;

    cacheline_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_address   (i_address),
        .i_read      (i_read),
        .i_write     (i_write),
        .i_wdata     (i_wdata),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_address   (d_address),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .mem_address (mem_address),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp)
    );

    always #5 clk = ~clk;

    // One comparison. Each call counts once, and a mismatch is reported.
    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] observed,
                               input logic [LINE_W-1:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
        end
    endtask

    // Drives both caches' request lines at once.
    task automatic applyStimulus(input logic iRd, input logic iWr, input logic [ADDR_W-1:0] iAddr,
                                 input logic [LINE_W-1:0] iData, input logic dRd, input logic dWr,
                                 input logic [ADDR_W-1:0] dAddr, input logic [LINE_W-1:0] dData);
        i_read    = iRd;
        i_write   = iWr;
        i_address = iAddr;
        i_wdata   = iData;
        d_read    = dRd;
        d_write   = dWr;
        d_address = dAddr;
        d_wdata   = dData;
    endtask

    // Counts falling edges until a downstream request appears. The wait is
    // bounded, and a timeout counts as a failed comparison.
    task automatic waitForRequest(output int n);
        logic seen;
        seen = 1'b0;
        n    = 0;
        repeat (20) begin
            #1;
            if (mem_read || mem_write) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        checkOutput("reqSeen", LINE_W'(seen), LINE_W'(1'b1));
    endtask

    // Acts as the adaptor for one transaction that is already visible. It
    // checks that the request stays stable for holdCycles cycles, then
    // responds with rdata. It then checks the routed response and the
    // following RECOVER cycle.
    task automatic serveOne(input string tag, input logic expIsI, input logic expRead,
                            input logic [ADDR_W-1:0] expAddr, input logic [LINE_W-1:0] expWdata,
                            input logic [LINE_W-1:0] rdata, input int holdCycles);
        for (int k = 0; k < holdCycles; k++) begin
            checkOutput({tag, "_addr"},  LINE_W'(mem_address), LINE_W'(expAddr));
            checkOutput({tag, "_read"},  LINE_W'(mem_read),    LINE_W'(expRead));
            checkOutput({tag, "_write"}, LINE_W'(mem_write),   LINE_W'(!expRead));
            checkOutput({tag, "_wdata"}, mem_wdata,            expWdata);
            @(negedge clk);
            #1;
        end
        mem_rdata = rdata;
        mem_resp  = 1'b1;
        #1;
        checkOutput({tag, "_respAddr"}, LINE_W'(mem_address), LINE_W'(expAddr));
        checkOutput({tag, "_iResp"},  LINE_W'(i_resp), LINE_W'(expIsI));
        checkOutput({tag, "_dResp"},  LINE_W'(d_resp), LINE_W'(!expIsI));
        checkOutput({tag, "_iRdata"}, i_rdata, expIsI ? rdata : '0);
        checkOutput({tag, "_dRdata"}, d_rdata, expIsI ? '0 : rdata);
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = '0;
        #1;
        checkOutput({tag, "_recRead"},  LINE_W'(mem_read),  '0);
        checkOutput({tag, "_recWrite"}, LINE_W'(mem_write), '0);
        checkOutput({tag, "_recResp"},  LINE_W'(i_resp | d_resp), '0);
    endtask

    initial begin
        rst       = 1'b1;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        #1;
        $display("[TB] reset values");
        checkOutput("rstMemRead",  LINE_W'(mem_read),    '0);
        checkOutput("rstMemWrite", LINE_W'(mem_write),   '0);
        checkOutput("rstMemAddr",  LINE_W'(mem_address), '0);
        checkOutput("rstMemWdata", mem_wdata,            '0);
        checkOutput("rstResp",     LINE_W'(i_resp | d_resp), '0);
        checkOutput("rstRdata",    i_rdata | d_rdata,    '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Tie directly after reset: icache first, dcache 3 cycles after resp.
        $display("[TB] tie from reset");
        applyStimulus(1'b1, 1'b0, 32'h100, '0, 1'b1, 1'b0, 32'h200, '0);
        waitForRequest(cycles);
        checkOutput("tieLatency", LINE_W'(cycles), LINE_W'(1));
        serveOne("tieI", 1'b1, 1'b1, 32'h100, '0, LINE_A, 3);
        i_read = 1'b0;
        waitForRequest(cycles);
        checkOutput("tieGapD", LINE_W'(cycles), LINE_W'(2));
        serveOne("tieD", 1'b0, 1'b1, 32'h200, '0, LINE_B, 2);
        d_read = 1'b0;
        @(negedge clk);

        // Both caches request continuously: grants must alternate I,D,I,D,I,D.
        $display("[TB] repeated ties");
        applyStimulus(1'b1, 1'b0, 32'h100, '0, 1'b1, 1'b0, 32'h200, '0);
        for (int t = 0; t < 6; t++) begin
            waitForRequest(cycles);
            if (t > 0) checkOutput("rrGap", LINE_W'(cycles), LINE_W'(2));
            if (t % 2 == 0) serveOne("rrI", 1'b1, 1'b1, 32'h100, '0, LINE_A, 1);
            else            serveOne("rrD", 1'b0, 1'b1, 32'h200, '0, LINE_B, 1);
        end
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);

        // Single icache read with a 5-cycle adaptor delay.
        $display("[TB] single icache read");
        applyStimulus(1'b1, 1'b0, 32'h0000_1000, '0, 1'b0, 1'b0, '0, '0);
        waitForRequest(cycles);
        checkOutput("iReadLatency", LINE_W'(cycles), LINE_W'(1));
        serveOne("iRead", 1'b1, 1'b1, 32'h0000_1000, '0, LINE_A, 5);
        i_read = 1'b0;
        @(negedge clk);

        // Single dcache write.
        $display("[TB] single dcache write");
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 32'h0000_2040, LINE_W0);
        waitForRequest(cycles);
        serveOne("dWrite", 1'b0, 1'b0, 32'h0000_2040, LINE_W0, '0, 4);
        d_write = 1'b0;
        @(negedge clk);

        // A mem_resp that arrives in IDLE must be ignored.
        $display("[TB] stray mem_resp in IDLE");
        mem_resp  = 1'b1;
        mem_rdata = LINE_A;
        #1;
        checkOutput("strayResp",  LINE_W'(i_resp | d_resp), '0);
        checkOutput("strayRdata", i_rdata | d_rdata, '0);
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = '0;
        #1;
        checkOutput("strayNoReq", LINE_W'(mem_read | mem_write), '0);
        @(negedge clk);

        // Requester address changes while BUSY; the latched address must hold.
        $display("[TB] input change during busy");
        applyStimulus(1'b1, 1'b0, 32'h100, '0, 1'b0, 1'b0, '0, '0);
        waitForRequest(cycles);
        i_address = 32'h200;
        serveOne("busyChg", 1'b1, 1'b1, 32'h100, '0, LINE_B, 4);
        i_read = 1'b0;
        @(negedge clk);

        // Reset in the middle of a read. The icache was granted last, so a
        // tie after reset still going to the icache shows last_grant was reset.
        $display("[TB] reset mid-read");
        applyStimulus(1'b1, 1'b0, 32'h300, '0, 1'b0, 1'b0, '0, '0);
        waitForRequest(cycles);
        checkOutput("rstPreRead", LINE_W'(mem_read), LINE_W'(1'b1));
        rst = 1'b1;
        #1;
        checkOutput("rstAsyncRead", LINE_W'(mem_read), '0);
        checkOutput("rstNoResp",    LINE_W'(i_resp), '0);
        i_read = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rstHoldResp", LINE_W'(i_resp | mem_read), '0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h100, '0, 1'b1, 1'b0, 32'h200, '0);
        waitForRequest(cycles);
        serveOne("postRstI", 1'b1, 1'b1, 32'h100, '0, LINE_A, 1);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

    // Guard against a hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
